c64_bus_arbiter: RTL
====================

# c64_bus_arbiter

Shares the single 64 KiB system memory bus between the 6502 core and the VIC-II video controller. Each CPU cycle is split into two `clk` phases: phi1 is always the VIC's, and phi2 is the CPU's unless the VIC has stolen the bus. Stealing follows the C64 BA/AEC discipline: BA drops, the CPU may finish writes for `STEAL_DELAY` cycles, then the VIC owns both phases. The block sits between the CPU/VIC address generators and the RAM/IO decoder, and supplies the CPU's clock enable and RDY.

## Interface
- `STEAL_DELAY`, default 3: phi2 phases between BA falling and VIC taking phi2; range 0..7.
- `clk`  in  1  system clock; one phase per cycle.
- `reset`  in  1  asynchronous, active-high.
- `cpu_ab`  in  16  CPU address.
- `cpu_do`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write request for the current cycle.
- `vic_ab`  in  16  VIC address (VIC is read-only).
- `vic_steal_req`  in  1  VIC wants phi2 (badline / sprite DMA).
- `phi2`  out  1  current phase; 0 = phi1, 1 = phi2.
- `cpu_en`  out  1  CPU clock enable; CPU advances on the edge ending a phase with `cpu_en`=1.
- `cpu_rdy`  out  1  0 means CPU read cycles are stalled.
- `ba`  out  1  bus available; 0 from the start of a steal.
- `vic_grant`  out  1  VIC owns the current phi2 (AEC low).
- `mem_ab`  out  16  memory address.
- `mem_do`  out  8  memory write data.
- `mem_we`  out  1  memory write strobe.

## Operation
- `phase` register toggles every `clk`. States: `CPU_OWN`, `STEAL_WAIT`, `VIC_OWN`; a 3-bit `steal_cnt`.
- State and counter update only on the edge ending a phi2 phase (`phi2`=1). `vic_steal_req` is sampled only on those edges.
- Transitions when `vic_steal_req`=1:
  - `CPU_OWN` → `STEAL_WAIT` with `steal_cnt`=`STEAL_DELAY`-1. If `STEAL_DELAY`=0, go straight to `VIC_OWN`.
  - `STEAL_WAIT` with `steal_cnt`=0 → `VIC_OWN`; otherwise decrement `steal_cnt`.
- Transitions when `vic_steal_req`=0:
  - `STEAL_WAIT` → `CPU_OWN` (steal aborted).
  - `VIC_OWN` → `CPU_OWN`.
- Outputs are combinational from `phase`, state and inputs:
  - `ba` = (state==`CPU_OWN`).
  - `cpu_rdy` = `ba`.
  - `vic_grant` = `phi2` & (state==`VIC_OWN`).
  - `cpu_en` = `phi2` & (state==`CPU_OWN` | (state==`STEAL_WAIT` & `cpu_we`)).
  - `mem_ab` = `cpu_en` ? `cpu_ab` : `vic_ab`.
  - `mem_we` = `cpu_en` & `cpu_we`.
  - `mem_do` = `cpu_do`; it is don't-care unless `mem_we`=1.
- A CPU read during `STEAL_WAIT` gets no `cpu_en`; the CPU holds `cpu_ab` until it is granted.

## Timing
- Reset values: `phase`=0, state `CPU_OWN`, `steal_cnt`=0, so `phi2`=0, `ba`=1, `cpu_rdy`=1, `vic_grant`=0, `cpu_en`=0, `mem_we`=0, `mem_ab`=`vic_ab`.
- First edge after reset release enters phi2, where the CPU is granted.
- Latency with steal:
  - `ba` falls on the phi1 immediately after the sampling phi2 edge.
  - `vic_grant` first rises `STEAL_DELAY` CPU cycles later, on phi2.
- Release latency: `ba` rises on the phi1 following the phi2 edge that sampled `vic_steal_req`=0.
- A request pulse shorter than one phi2 sampling edge is ignored.
- Reset mid-steal returns to the reset values immediately, since reset is asynchronous.

## Configuration
- `ARB_STEAL_EN` defined: full behaviour as above.
- `ARB_STEAL_EN` undefined:
  - State machine and counter are compiled out, and `vic_steal_req` is ignored.
  - `ba`=`cpu_rdy`=1 and `vic_grant`=0.
  - `cpu_en`=`phi2`; phase alternation is unchanged.

## Structure
- Shared package `c64_pkg` holds:
  - the state encoding `arb_state_t` (`CPU_OWN`=0, `STEAL_WAIT`=1, `VIC_OWN`=2);
  - the phase constants `PHI1`/`PHI2`;
  - `ADDR_W`=16 and `DATA_W`=8.
- One natural sub-module: `bus_phase_gen`, which owns the phase toggle and exports the `phi2` and `phi2_end` strobes. The steal FSM and the mux stay in the top module.

## Test plan
- Reset, then 4 clocks, with `cpu_ab`=16'h1000 and `vic_ab`=16'h0400:
  - `mem_ab` alternates 0400 / 1000 / 0400 / 1000.
  - `cpu_en` is 0,1,0,1.
  - `ba`=1 throughout.
- `vic_steal_req`=1 sampled with `STEAL_DELAY`=3 and CPU reading:
  - `ba` falls next phi1.
  - `cpu_en`=0 for 3 phi2 phases.
  - `vic_grant`=1 from the 4th phi2, and `mem_ab`=`vic_ab` on both phases.
- Same as above but `cpu_we`=1, `cpu_do`=8'hA5, `cpu_ab`=16'hD020 during `STEAL_WAIT`:
  - `mem_we`=1 with `mem_ab`=D020 and `mem_do`=A5 on each of the 3 phi2 phases.
  - `vic_grant` still rises on the 4th phi2.
- Drop `vic_steal_req` after 1 `STEAL_WAIT` phi2:
  - Abort to `CPU_OWN`; `ba`=1 next phi1.
  - `vic_grant` never asserts.
- Assert `reset` during `VIC_OWN`:
  - `vic_grant`=0, `ba`=1 and `phi2`=0 immediately.
  - After release, the CPU gets `cpu_en` on the first phi2.
- Build without `ARB_STEAL_EN`, hold `vic_steal_req`=1 for 20 clocks:
  - `ba`=1 and `vic_grant`=0 throughout.
  - `cpu_en` toggles every clock.

Source files
------------

// File: rtl/c64_pkg.sv
// rtl/c64_pkg.sv - shared bus widths, phase constants and arbiter state encoding
package c64_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic PHI1 = 1'b0;
   localparam logic PHI2 = 1'b1;

   typedef enum logic [1:0] {
      CPU_OWN    = 2'd0,
      STEAL_WAIT = 2'd1,
      VIC_OWN    = 2'd2
   } arb_state_t;
endpackage

// File: rtl/bus_phase_gen.sv
// rtl/bus_phase_gen.sv - phi1/phi2 phase toggle, one phase per clk
module bus_phase_gen
   import c64_pkg::*;
(
   input  logic clk,
   input  logic reset,
   output logic phi2,
   output logic phi2_end
);
   logic phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) phase <= PHI1;
      else       phase <= ~phase;
   end

   assign phi2     = (phase == PHI2);
   // The edge closing the current cycle ends a phi2 phase exactly when we are in phi2.
   assign phi2_end = (phase == PHI2);
endmodule

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - CPU/VIC-II memory bus arbiter with BA/AEC cycle stealing
// Optional feature macro: ARB_STEAL_EN (undefined: CPU always owns phi2).
module c64_bus_arbiter
   import c64_pkg::*;
#(
   parameter int STEAL_DELAY = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_ab,
   input  logic [DATA_W-1:0] cpu_do,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] vic_ab,
   input  logic              vic_steal_req,
   output logic              phi2,
   output logic              cpu_en,
   output logic              cpu_rdy,
   output logic              ba,
   output logic              vic_grant,
   output logic [ADDR_W-1:0] mem_ab,
   output logic [DATA_W-1:0] mem_do,
   output logic              mem_we
);
   logic phi2_end;

   bus_phase_gen u_phase (
      .clk      (clk),
      .reset    (reset),
      .phi2     (phi2),
      .phi2_end (phi2_end)
   );

`ifdef ARB_STEAL_EN
   localparam logic [2:0] CNT_INIT = (STEAL_DELAY == 0) ? 3'd0 : 3'(STEAL_DELAY - 1);

   arb_state_t state;
   logic [2:0] steal_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CPU_OWN;
         steal_cnt <= 3'd0;
      end else if (phi2_end) begin
         case (state)
            CPU_OWN: begin
               if (vic_steal_req) begin
                  if (STEAL_DELAY == 0) begin
                     state <= VIC_OWN;
                  end else begin
                     state     <= STEAL_WAIT;
                     steal_cnt <= CNT_INIT;
                  end
               end
            end
            STEAL_WAIT: begin
               if (!vic_steal_req)       state     <= CPU_OWN;
               else if (steal_cnt == 0)  state     <= VIC_OWN;
               else                      steal_cnt <= steal_cnt - 3'd1;
            end
            VIC_OWN: begin
               if (!vic_steal_req) state <= CPU_OWN;
            end
            default: state <= CPU_OWN;
         endcase
      end
   end

   // During the BA-low window only writes may complete; reads stall on RDY.
   always_comb begin
      ba        = (state == CPU_OWN);
      cpu_rdy   = ba;
      vic_grant = phi2 & (state == VIC_OWN);
      cpu_en    = phi2 & ((state == CPU_OWN) | ((state == STEAL_WAIT) & cpu_we));
   end
`else
   logic unused_steal;
   assign unused_steal = ^{vic_steal_req, phi2_end, 3'(STEAL_DELAY)};

   always_comb begin
      ba        = 1'b1;
      cpu_rdy   = 1'b1;
      vic_grant = 1'b0;
      cpu_en    = phi2;
   end
`endif

   assign mem_ab = cpu_en ? cpu_ab : vic_ab;
   assign mem_we = cpu_en & cpu_we;
   assign mem_do = cpu_do;
endmodule
